// File: rtl/conv_result_collector.sv
// Per-(channel,column) result banks absorbing row writes; once the last bank's last row lands,
// the whole tensor drains as one valid/ready stream in channel-major raster order, then rearms.
module conv_result_collector #(
   parameter int DATA_WIDTH          = 8,
   parameter int RESULT_W            = 6,
   parameter int RESULT_H            = 6,
   parameter int RESULT_D            = 4,
   parameter int RESULT_H_ADDR_WIDTH = $clog2(RESULT_H)
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic [RESULT_D*RESULT_W*RESULT_H_ADDR_WIDTH-1:0] result_wraddress,
   input  logic [RESULT_D*RESULT_W*DATA_WIDTH-1:0]          result_data_in,
   input  logic [RESULT_D*RESULT_W-1:0]                     result_wren,
   output logic [DATA_WIDTH-1:0]                            out_data,
   output logic                                             out_val,
   input  logic                                             out_rdy,
   output logic                                             out_last,
   output logic                                             busy,
   output logic                                             wr_drop
);

   localparam int NB = RESULT_D * RESULT_W;
   localparam int AW = RESULT_H_ADDR_WIDTH;
   localparam int BW = $clog2(NB > 1 ? NB : 2);
   localparam int WW = $clog2(RESULT_W > 1 ? RESULT_W : 2);
   localparam int DW = $clog2(RESULT_D > 1 ? RESULT_D : 2);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t                state_q;
   logic [DW-1:0]         d_q, d_d;
   logic [AW-1:0]         h_q, h_d;
   logic [WW-1:0]         w_q, w_d;
   logic                  all_loaded_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_val_q, out_last_q, wr_drop_q;
   logic [DATA_WIDTH-1:0] mem_q [NB][RESULT_H];

   logic [NB-1:0]         addr_ok;
   logic                  complete, drop_now, load, accept_last;
   logic                  w_last, h_last, d_last;
   logic [BW-1:0]         rd_bank;

   always_comb begin
      addr_ok = '0;
      for (int b = 0; b < NB; b++) begin
         addr_ok[b] = 32'(result_wraddress[b*AW +: AW]) < $unsigned(RESULT_H);
      end
   end

   always_comb begin
      complete    = (state_q == COLLECT) && result_wren[NB-1] &&
                    (result_wraddress[(NB-1)*AW +: AW] == AW'(RESULT_H - 1));
      // Any write at all during the drain is refused, regardless of address.
      drop_now    = (state_q == COLLECT) ? |(result_wren & ~addr_ok) : |result_wren;
      w_last      = (w_q == WW'(RESULT_W - 1));
      h_last      = (h_q == AW'(RESULT_H - 1));
      d_last      = (d_q == DW'(RESULT_D - 1));
      w_d         = w_last ? '0 : w_q + 1'b1;
      h_d         = w_last ? (h_last ? '0 : h_q + 1'b1) : h_q;
      d_d         = (w_last && h_last) ? (d_last ? '0 : d_q + 1'b1) : d_q;
      rd_bank     = BW'(int'(d_q) * RESULT_W + int'(w_q));
      load        = (state_q == DRAIN) && !all_loaded_q && (!out_val_q || out_rdy);
      accept_last = out_val_q && out_rdy && out_last_q;
   end

   // Bank contents are deliberately never cleared; only writes in COLLECT land.
   always_ff @(posedge clk) begin
      if (state_q == COLLECT) begin
         for (int b = 0; b < NB; b++) begin
            if (result_wren[b] && addr_ok[b]) begin
               mem_q[b][result_wraddress[b*AW +: AW]] <= result_data_in[b*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= COLLECT;
         d_q          <= '0;
         h_q          <= '0;
         w_q          <= '0;
         all_loaded_q <= 1'b0;
         out_data_q   <= '0;
         out_val_q    <= 1'b0;
         out_last_q   <= 1'b0;
         wr_drop_q    <= 1'b0;
      end else begin
         if (drop_now) wr_drop_q <= 1'b1;
         case (state_q)
            COLLECT: begin
               if (complete) state_q <= DRAIN;
            end
            DRAIN: begin
               if (accept_last) begin
                  state_q      <= COLLECT;
                  d_q          <= '0;
                  h_q          <= '0;
                  w_q          <= '0;
                  all_loaded_q <= 1'b0;
                  out_val_q    <= 1'b0;
                  out_last_q   <= 1'b0;
               end else if (load) begin
                  out_data_q   <= mem_q[rd_bank][h_q];
                  out_val_q    <= 1'b1;
                  out_last_q   <= d_last && h_last && w_last;
                  all_loaded_q <= d_last && h_last && w_last;
                  d_q          <= d_d;
                  h_q          <= h_d;
                  w_q          <= w_d;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign out_data = out_data_q;
   assign out_val  = out_val_q;
   assign out_last = out_last_q;
   assign busy     = (state_q == DRAIN);
   assign wr_drop  = wr_drop_q;

endmodule
